// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory arbiter
package dmem_pkg;

    localparam int DEPTH_DEF = 256;
    localparam int AW_DEF    = 32;
    localparam int DW_DEF    = 32;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    typedef struct packed {
        logic [DW_DEF-1:0] rdata;
        logic              err;
    } rsp_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_rsp_slot.sv
// rtl/dmem_rsp_slot.sv - per-port response buffer, eligibility and stall counter
module dmem_rsp_slot
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic              in_range,
    input  logic              grant,
    input  logic              rsp_ready,
    input  logic [DW_DEF-1:0] mem_rdata,
    output logic              eligible,
    output logic              rsp_valid,
    output rsp_t              rsp,
    output logic [CNT_W-1:0]  stall_cnt
);

    // A pending response may be drained in the same cycle a new request lands.
    assign eligible = req_valid & (~rsp_valid | rsp_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp       <= '0;
            stall_cnt <= '0;
        end else begin
            if (grant) begin
                rsp_valid <= 1'b1;
                rsp.err   <= ~in_range;
                rsp.rdata <= (!req_we && in_range) ? mem_rdata : '0;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp       <= '0;
            end

            if (req_valid && !grant) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter in front of a single-port data memory
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             p0_req_valid,
    input  logic             p0_req_we,
    input  logic [AW-1:0]    p0_req_addr,
    input  logic [DW-1:0]    p0_req_wdata,
    output logic             p0_req_ready,
    output logic             p0_rsp_valid,
    input  logic             p0_rsp_ready,
    output logic [DW-1:0]    p0_rsp_rdata,
    output logic             p0_rsp_err,

    input  logic             p1_req_valid,
    input  logic             p1_req_we,
    input  logic [AW-1:0]    p1_req_addr,
    input  logic [DW-1:0]    p1_req_wdata,
    output logic             p1_req_ready,
    output logic             p1_rsp_valid,
    input  logic             p1_rsp_ready,
    output logic [DW-1:0]    p1_rsp_rdata,
    output logic             p1_rsp_err,

    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,

    output logic [CNT_W-1:0] p0_stall_cnt,
    output logic [CNT_W-1:0] p1_stall_cnt
);

    port_e prio;
    logic  in_range0, in_range1;
    logic  eligible0, eligible1;
    logic  grant0, grant1;
    rsp_t  rsp0, rsp1;

    assign in_range0 = p0_req_addr < AW'(DEPTH);
    assign in_range1 = p1_req_addr < AW'(DEPTH);

    // Grants are suppressed during reset so nothing reaches the memory pins.
    assign grant0 = reset & eligible0 & (~eligible1 | (prio == PORT0));
    assign grant1 = reset & eligible1 & (~eligible0 | (prio == PORT1));

    assign p0_req_ready = grant0;
    assign p1_req_ready = grant1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio <= PORT0;
        end else if (grant0) begin
            prio <= PORT1;
        end else if (grant1) begin
            prio <= PORT0;
        end
    end

    assign mem_addr  = grant1 ? p1_req_addr  : p0_req_addr;
    assign mem_wdata = grant1 ? p1_req_wdata : p0_req_wdata;
    assign mem_we    = (grant0 & p0_req_we & in_range0) | (grant1 & p1_req_we & in_range1);

    dmem_rsp_slot u_slot0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (p0_req_valid),
        .req_we    (p0_req_we),
        .in_range  (in_range0),
        .grant     (grant0),
        .rsp_ready (p0_rsp_ready),
        .mem_rdata (mem_rdata),
        .eligible  (eligible0),
        .rsp_valid (p0_rsp_valid),
        .rsp       (rsp0),
        .stall_cnt (p0_stall_cnt)
    );

    dmem_rsp_slot u_slot1 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (p1_req_valid),
        .req_we    (p1_req_we),
        .in_range  (in_range1),
        .grant     (grant1),
        .rsp_ready (p1_rsp_ready),
        .mem_rdata (mem_rdata),
        .eligible  (eligible1),
        .rsp_valid (p1_rsp_valid),
        .rsp       (rsp1),
        .stall_cnt (p1_stall_cnt)
    );

    assign p0_rsp_rdata = rsp0.rdata;
    assign p0_rsp_err   = rsp0.err;
    assign p1_rsp_rdata = rsp1.rdata;
    assign p1_rsp_err   = rsp1.err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        v[2], we[2], rr[2];
    logic [31:0] ad[2], wd[2];

    logic        p0_req_ready, p0_rsp_valid, p0_rsp_err;
    logic        p1_req_ready, p1_rsp_valid, p1_rsp_err;
    logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] p0_stall_cnt, p1_stall_cnt;

    dmem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .p0_req_valid (v[0]),
        .p0_req_we    (we[0]),
        .p0_req_addr  (ad[0]),
        .p0_req_wdata (wd[0]),
        .p0_req_ready (p0_req_ready),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_ready (rr[0]),
        .p0_rsp_rdata (p0_rsp_rdata),
        .p0_rsp_err   (p0_rsp_err),
        .p1_req_valid (v[1]),
        .p1_req_we    (we[1]),
        .p1_req_addr  (ad[1]),
        .p1_req_wdata (wd[1]),
        .p1_req_ready (p1_req_ready),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_ready (rr[1]),
        .p1_rsp_rdata (p1_rsp_rdata),
        .p1_rsp_err   (p1_rsp_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .p0_stall_cnt (p0_stall_cnt),
        .p1_stall_cnt (p1_stall_cnt)
    );

    logic        d_rdy[2], d_rv[2], d_err[2];
    logic [31:0] d_rd[2];
    logic [15:0] d_st[2];
    assign d_rdy[0] = p0_req_ready;  assign d_rdy[1] = p1_req_ready;
    assign d_rv[0]  = p0_rsp_valid;  assign d_rv[1]  = p1_rsp_valid;
    assign d_err[0] = p0_rsp_err;    assign d_err[1] = p1_rsp_err;
    assign d_rd[0]  = p0_rsp_rdata;  assign d_rd[1]  = p1_rsp_rdata;
    assign d_st[0]  = p0_stall_cnt;  assign d_st[1]  = p1_stall_cnt;

    // Physical memory the arbiter drives: combinational read, synchronous write.
    logic [31:0] env_mem[DEPTH];
    assign mem_rdata = (mem_addr < 32'(DEPTH)) ? env_mem[mem_addr[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr[7:0]] <= mem_wdata;
    end

    // Reference model: expected memory contents, pending responses, fairness state.
    logic [31:0] ref_mem[DEPTH];
    bit          m_rv[2], m_err[2];
    logic [31:0] m_rd[2];
    int          m_stall[2];
    int          m_favor;
    int          g;
    bit          e_we;

    int checks = 0;
    int failures = 0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = 0; m_err[i] = 0; m_rd[i] = 32'h0; m_stall[i] = 0;
        end
        m_favor = 0;
    endtask

    task automatic model_eval();
        bit want[2];
        for (int i = 0; i < 2; i++) want[i] = v[i] && (!m_rv[i] || rr[i]);
        if (want[0] && want[1]) g = m_favor;
        else if (want[0])       g = 0;
        else if (want[1])       g = 1;
        else                    g = -1;
        e_we = (g >= 0) && we[g] && (ad[g] < 32'(DEPTH));
    endtask

    task automatic model_advance();
        for (int i = 0; i < 2; i++) begin
            if (g == i) begin
                m_rv[i]  = 1;
                m_err[i] = !(ad[i] < 32'(DEPTH));
                m_rd[i]  = (!we[i] && !m_err[i]) ? ref_mem[ad[i][7:0]] : 32'h0;
            end else if (m_rv[i] && rr[i]) begin
                m_rv[i] = 0; m_err[i] = 0; m_rd[i] = 32'h0;
            end
            if (v[i] && g != i && m_stall[i] < 65535) m_stall[i]++;
        end
        if (e_we) ref_mem[ad[g][7:0]] = wd[g];
        if (g >= 0) m_favor = 1 - g;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            v[i] = 0; we[i] = 0; rr[i] = 1; ad[i] = 32'h0; wd[i] = 32'h0;
        end
    endtask

    task automatic reset_dut();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        v[0] = 1; we[0] = 1; ad[0] = 32'd3; wd[0] = 32'h1234_5678;
        #2;
        checks++;
        if (mem_we !== 1'b0) begin
            failures++; $display("FAIL reset_mem_we: got %b want 0", mem_we);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (d_rv[i] !== 1'b0 || d_rd[i] !== 32'h0 || d_err[i] !== 1'b0 || d_st[i] !== 16'h0) begin
                failures++;
                $display("FAIL reset_state port%0d: got rv=%b rd=%h err=%b st=%h want all zero",
                         i, d_rv[i], d_rd[i], d_err[i], d_st[i]);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_inputs();
        model_reset();
    endtask

    task automatic test_write_read();
        v[0] = 1; we[0] = 1; ad[0] = 32'd5; wd[0] = 32'hDEADBEEF;
        settle();
        checks++;
        if (p0_req_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd5 || mem_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_drive: got rdy=%b we=%b a=%h wd=%h want 1 1 5 deadbeef",
                     p0_req_ready, mem_we, mem_addr, mem_wdata);
        end
        tick();
        we[0] = 0;
        settle();
        checks++;
        if (p0_req_ready !== 1'b1 || mem_we !== 1'b0 || p0_rsp_valid !== 1'b1 ||
            p0_rsp_err !== 1'b0 || p0_rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL wr_rsp: got rdy=%b we=%b rv=%b err=%b rd=%h want 1 0 1 0 0",
                     p0_req_ready, mem_we, p0_rsp_valid, p0_rsp_err, p0_rsp_rdata);
        end
        tick();
        v[0] = 0;
        settle();
        checks++;
        if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'hDEADBEEF || p0_rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL rd_rsp: got rv=%b rd=%h err=%b want 1 deadbeef 0",
                     p0_rsp_valid, p0_rsp_rdata, p0_rsp_err);
        end
        tick();
        settle();
        checks++;
        if (p0_rsp_valid !== 1'b0 || p0_rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rd_drain: got rv=%b rd=%h want 0 0", p0_rsp_valid, p0_rsp_rdata);
        end
        tick();
    endtask

    task automatic test_alternate();
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 2; i++) begin
                v[i] = 1; we[i] = 0; rr[i] = 1; ad[i] = $urandom_range(0, DEPTH - 1);
            end
            settle();
            checks++;
            if (p0_req_ready !== (k % 2 == 0) || p1_req_ready !== (k % 2 == 1)) begin
                failures++;
                $display("FAIL alt_grant cycle%0d: got %b%b want %b%b", k,
                         p0_req_ready, p1_req_ready, k % 2 == 0, k % 2 == 1);
            end
            checks++;
            if (p0_stall_cnt !== 16'(k / 2) || p1_stall_cnt !== 16'((k + 1) / 2)) begin
                failures++;
                $display("FAIL alt_stall cycle%0d: got %0d/%0d want %0d/%0d", k,
                         p0_stall_cnt, p1_stall_cnt, k / 2, (k + 1) / 2);
            end
            checks++;
            if (p0_rsp_rdata !== m_rd[0] || p1_rsp_rdata !== m_rd[1]) begin
                failures++;
                $display("FAIL alt_rdata cycle%0d: got %h/%h want %h/%h", k,
                         p0_rsp_rdata, p1_rsp_rdata, m_rd[0], m_rd[1]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_blocked_port();
        logic [31:0] held;
        reset_dut();
        v[0] = 1; we[0] = 0; rr[0] = 0; ad[0] = $urandom_range(0, DEPTH - 1);
        held = ref_mem[ad[0][7:0]];
        settle();
        checks++;
        if (p0_req_ready !== 1'b1) begin
            failures++; $display("FAIL blk_first: got %b want 1", p0_req_ready);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            v[1] = 1; we[1] = 0; rr[1] = 1; ad[1] = $urandom_range(0, DEPTH - 1);
            settle();
            checks++;
            if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b1) begin
                failures++;
                $display("FAIL blk_grant step%0d: got p0=%b p1=%b want 0 1", k, p0_req_ready, p1_req_ready);
            end
            checks++;
            if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== held) begin
                failures++;
                $display("FAIL blk_hold step%0d: got rv=%b rd=%h want 1 %h", k, p0_rsp_valid, p0_rsp_rdata, held);
            end
            if (k > 0) begin
                checks++;
                if (p1_rsp_valid !== 1'b1 || p1_rsp_rdata !== m_rd[1]) begin
                    failures++;
                    $display("FAIL blk_p1rsp step%0d: got rv=%b rd=%h want 1 %h", k, p1_rsp_valid, p1_rsp_rdata, m_rd[1]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_out_of_range();
        int bad;
        reset_dut();
        v[1] = 1; we[1] = 1; ad[1] = 32'd256; wd[1] = $urandom;
        settle();
        checks++;
        if (p1_req_ready !== 1'b1 || mem_we !== 1'b0) begin
            failures++; $display("FAIL oor_drive: got rdy=%b we=%b want 1 0", p1_req_ready, mem_we);
        end
        tick();
        v[1] = 0;
        settle();
        checks++;
        if (p1_rsp_valid !== 1'b1 || p1_rsp_err !== 1'b1 || p1_rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL oor_rsp: got rv=%b err=%b rd=%h want 1 1 0", p1_rsp_valid, p1_rsp_err, p1_rsp_rdata);
        end
        tick();
        bad = 0;
        for (int a = 0; a < DEPTH; a++) if (env_mem[a] !== ref_mem[a]) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL oor_mem: got %0d changed words want 0", bad);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 2; i++) begin
                rr[i] = ($urandom_range(0, 3) != 0);
                if (!(v[i] && g != i) || k == 0) begin
                    v[i]  = ($urandom_range(0, 3) != 0);
                    we[i] = $urandom_range(0, 1);
                    ad[i] = ($urandom_range(0, 7) == 0) ? 32'(DEPTH + $urandom_range(0, 999))
                                                        : 32'($urandom_range(0, DEPTH - 1));
                    wd[i] = $urandom;
                end
            end
            settle();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (d_rdy[i] !== (g == i) || d_rv[i] !== m_rv[i] || d_err[i] !== m_err[i] ||
                    d_rd[i] !== m_rd[i] || d_st[i] !== 16'(m_stall[i])) begin
                    failures++;
                    $display("FAIL rnd_port%0d cycle%0d: got rdy=%b rv=%b err=%b rd=%h st=%0d want %b %b %b %h %0d",
                             i, k, d_rdy[i], d_rv[i], d_err[i], d_rd[i], d_st[i],
                             g == i, m_rv[i], m_err[i], m_rd[i], m_stall[i]);
                end
            end
            checks++;
            if (mem_we !== e_we || (g >= 0 && mem_addr !== ad[g])) begin
                failures++;
                $display("FAIL rnd_mem cycle%0d: got we=%b a=%h want we=%b grant=%0d", k, mem_we, mem_addr, e_we, g);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] w1, keep11;
        reset_dut();
        w1 = $urandom;
        keep11 = ref_mem[11];
        v[0] = 1; we[0] = 1; ad[0] = 32'd10; wd[0] = w1;
        settle();
        checks++;
        if (p0_req_ready !== 1'b1 || mem_we !== 1'b1) begin
            failures++; $display("FAIL rmo_accept: got rdy=%b we=%b want 1 1", p0_req_ready, mem_we);
        end
        tick();
        ad[0] = 32'd11; wd[0] = ~w1;
        reset = 1'b0;
        #1;
        checks++;
        if (p0_rsp_valid !== 1'b0 || mem_we !== 1'b0) begin
            failures++; $display("FAIL rmo_async: got rv=%b we=%b want 0 0", p0_rsp_valid, mem_we);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (mem_we !== 1'b0) begin
                failures++; $display("FAIL rmo_we cycle%0d: got %b want 0", k, mem_we);
            end
            @(posedge clk);
        end
        #1;
        checks++;
        if (env_mem[10] !== w1 || env_mem[11] !== keep11) begin
            failures++;
            $display("FAIL rmo_mem: got %h/%h want %h/%h", env_mem[10], env_mem[11], w1, keep11);
        end
        model_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1; we[i] = 0; rr[i] = 1; ad[i] = 32'(i);
        end
        settle();
        checks++;
        if (p0_req_ready !== 1'b1 || p1_req_ready !== 1'b0) begin
            failures++; $display("FAIL rmo_ptr: got %b%b want 10", p0_req_ready, p1_req_ready);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_stall_saturation();
        reset_dut();
        v[0] = 1; we[0] = 0; rr[0] = 0; ad[0] = 32'd0;
        for (int k = 0; k <= 65600; k++) begin
            @(negedge clk);
            if (k == 1000) begin
                checks++;
                if (p0_stall_cnt !== 16'd999) begin
                    failures++; $display("FAIL sat_mid: got %0d want 999", p0_stall_cnt);
                end
            end
            if (k == 65536) begin
                checks++;
                if (p0_stall_cnt !== 16'hFFFF) begin
                    failures++; $display("FAIL sat_reach: got %h want ffff", p0_stall_cnt);
                end
            end
            @(posedge clk);
        end
        #1;
        checks++;
        if (p0_stall_cnt !== 16'hFFFF || p0_req_ready !== 1'b0 || p1_stall_cnt !== 16'h0) begin
            failures++;
            $display("FAIL sat_hold: got p0=%h rdy=%b p1=%h want ffff 0 0", p0_stall_cnt, p0_req_ready, p1_stall_cnt);
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        g = -1;
        for (int a = 0; a < DEPTH; a++) begin
            ref_mem[a] = $urandom;
            env_mem[a] = ref_mem[a];
        end
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_alternate();
        test_blocked_port();
        test_out_of_range();
        test_random();
        test_reset_mid_op();
        test_stall_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-port data memory (combinational read, synchronous write, word-addressed) between the core load/store path (port 0) and the DMA/debug path (port 1). Uses round-robin arbitration with valid/ready request handshakes and a one-entry registered response buffer per port. Sits between the requesters and the data memory and drives its WE/A/WD pins directly. Also keeps per-port saturating stall counters for debug visibility.

Parameters:
DEPTH, 256, number of memory words; valid addresses are 0..DEPTH-1
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
p0_req_valid  in  1  port 0 request present
p0_req_we  in  1  port 0 write (1) / read (0)
p0_req_addr  in  AW  port 0 word address
p0_req_wdata  in  DW  port 0 write data
p0_req_ready  out  1  port 0 request accepted this cycle
p0_rsp_valid  out  1  port 0 response pending
p0_rsp_ready  in  1  port 0 consumes response
p0_rsp_rdata  out  DW  read data; 0 for writes and errors
p0_rsp_err  out  1  address out of range
p1_*  same nine signals as p0_*, for port 1
mem_we  out  1  to memory WE
mem_addr  out  AW  to memory A
mem_wdata  out  DW  to memory WD
mem_rdata  in  DW  from memory RD (combinational)
p0_stall_cnt  out  16  cycles with p0_req_valid=1 and p0_req_ready=0, saturating
p1_stall_cnt  out  16  same, for port 1

Behaviour:
- Reset (reset=0, asynchronous): rsp_valid/rsp_rdata/rsp_err = 0 for both ports; stall counters = 0; priority pointer = port 0. mem_we is forced to 0 while reset is low.
- Eligibility: port i is eligible when req_valid_i=1 and (rsp_valid_i=0 or rsp_ready_i=1). Draining a response and accepting a new request in the same cycle is allowed.
- Grant (combinational):
  - Only one port eligible: that port is granted.
  - Both eligible: the port indicated by the priority pointer is granted.
  - Neither eligible: no grant.
- req_ready_i = grant_i. A request is accepted when req_valid_i and req_ready_i are both 1.
- Pointer update: on any grant, the pointer moves to the other port at the clock edge. No grant leaves the pointer unchanged.
- Memory drive:
  - mem_addr and mem_wdata follow the granted port. When idle they hold port 0's values.
  - mem_we = grant & req_we & in_range, where in_range = (addr < DEPTH).
  - An out-of-range write never reaches the memory.
- Response (registered, 1-cycle latency): at the edge after acceptance, rsp_valid_i<=1 and rsp_err_i<=!in_range.
  - In-range read: rsp_rdata_i <= mem_rdata sampled in the acceptance cycle, i.e. pre-write contents.
  - Write or error: rsp_rdata_i <= 0.
- Response hold: rsp_valid_i stays 1 and data stays stable until rsp_ready_i=1. On drain with no new acceptance, rsp_valid_i<=0 and data<=0.
- Per-port independence: a port blocked by its own pending response does not block the other port; the other port may take back-to-back grants.
- Throughput: one access per cycle total. Two continuously eligible ports alternate p0,p1,p0,...
- Stall counters: increment when req_valid_i & !req_ready_i; saturate at 16'hFFFF; never clear except on reset.
- Reset mid-operation: any pending responses are discarded and no write commits on or after the reset-assert cycle.
- Requesters must hold request fields stable while valid and not ready. The arbiter does not check this.

Decomposition:
- Shared package dmem_pkg: DEPTH, AW, DW defaults; response struct fields (rdata, err); stall counter width 16 and saturation constant.
- One sub-module, dmem_rsp_slot, instantiated per port. It contains the response buffer register, the eligibility logic and the stall counter. The top level holds the round-robin pointer, grant logic and memory mux.

Test Plan:
- Reset, then p0 writes 0xDEADBEEF to addr 5, then p0 reads addr 5 -> mem_we=1 only in the write cycle; read rsp_rdata=0xDEADBEEF, err=0, rsp_valid 1 cycle after acceptance.
- Both ports read continuously with rsp_ready=1, pointer at 0 after reset -> grants alternate p0,p1,p0,p1; each port's stall_cnt rises by 1 every other cycle.
- p0 rsp_ready held 0 with p0 pending, p1 issues 3 reads -> p0_req_ready=0, p1 granted 3 consecutive cycles, p0 response held stable throughout.
- p1 writes to addr 256 (DEPTH=256) -> mem_we stays 0, p1_rsp_err=1, rsp_rdata=0; memory unchanged (read addr 0..255 unaffected).
- p0 requests continuously while its response is never consumed for 70000 cycles -> p0_stall_cnt saturates at 0xFFFF and does not wrap.
- Reset asserted the cycle after p0 write acceptance -> rsp_valid cleared immediately (asynchronous), pointer back to 0, no further mem_we until reset is released.
